// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared timing defaults, colour codes, pattern codes and the
//               bouncing-box FSM encoding for the VGA pattern generator.
// Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Default 640x480 timing (pixels/lines including blanking)
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_COLOR_BITS  = 3;
  localparam int DEF_BOX_SIZE    = 32;

  // 3-bit colour codes, {red, green, blue}
  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // Pattern select codes; 6 and 7 fall through to black
  localparam logic [2:0] PAT_BLACK   = 3'd0;
  localparam logic [2:0] PAT_WHITE   = 3'd1;
  localparam logic [2:0] PAT_BARS    = 3'd2;
  localparam logic [2:0] PAT_CHECKER = 3'd3;
  localparam logic [2:0] PAT_BOX     = 3'd4;
  localparam logic [2:0] PAT_RAMP    = 3'd5;

  // Bouncing-box motion FSM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2
  } box_state_t;

  // Colour-bar order, left to right
  function automatic logic [2:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = WHITE;
      3'd1:    bar_colour = YELLOW;
      3'd2:    bar_colour = CYAN;
      3'd3:    bar_colour = GREEN;
      3'd4:    bar_colour = MAGENTA;
      3'd5:    bar_colour = RED;
      3'd6:    bar_colour = BLUE;
      default: bar_colour = BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ============================================================================
// Module      : vga_box_mover
// Description : Moves the bouncing box one pixel in X then one in Y per
//               frame-blank strobe, reflecting at the active-area edges.
// Revision    : 1.0  initial release
// ============================================================================
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int BOX_SIZE    = DEF_BOX_SIZE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       strobe,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0] c_max_x = 10'(ACTIVE_COLS - BOX_SIZE);
  localparam logic [9:0] c_max_y = 10'(ACTIVE_ROWS - BOX_SIZE);

  box_state_t r_state, w_state_nxt;
  logic [9:0] r_box_x, w_box_x_nxt;
  logic [9:0] r_box_y, w_box_y_nxt;
  logic       r_dir_x, w_dir_x_nxt;   // 1 = moving +1, 0 = moving -1
  logic       r_dir_y, w_dir_y_nxt;

  // State, position and direction registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_box_x <= 10'd0;
      r_box_y <= 10'd0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_box_x <= w_box_x_nxt;
      r_box_y <= w_box_y_nxt;
      r_dir_x <= w_dir_x_nxt;
      r_dir_y <= w_dir_y_nxt;
    end
  end

  // Next-state: one X step then one Y step per strobe, reversing at the limits
  always_comb begin
    w_state_nxt = r_state;
    w_box_x_nxt = r_box_x;
    w_box_y_nxt = r_box_y;
    w_dir_x_nxt = r_dir_x;
    w_dir_y_nxt = r_dir_y;
    case (r_state)
      IDLE: begin
        if (strobe) w_state_nxt = STEP_X;
      end
      STEP_X: begin
        if (r_dir_x && (r_box_x == c_max_x)) begin
          w_dir_x_nxt = 1'b0;
          w_box_x_nxt = r_box_x - 10'd1;
        end else if (!r_dir_x && (r_box_x == 10'd0)) begin
          w_dir_x_nxt = 1'b1;
          w_box_x_nxt = r_box_x + 10'd1;
        end else if (r_dir_x) begin
          w_box_x_nxt = r_box_x + 10'd1;
        end else begin
          w_box_x_nxt = r_box_x - 10'd1;
        end
        w_state_nxt = STEP_Y;
      end
      STEP_Y: begin
        if (r_dir_y && (r_box_y == c_max_y)) begin
          w_dir_y_nxt = 1'b0;
          w_box_y_nxt = r_box_y - 10'd1;
        end else if (!r_dir_y && (r_box_y == 10'd0)) begin
          w_dir_y_nxt = 1'b1;
          w_box_y_nxt = r_box_y + 10'd1;
        end else if (r_dir_y) begin
          w_box_y_nxt = r_box_y + 10'd1;
        end else begin
          w_box_y_nxt = r_box_y - 10'd1;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign box_x = r_box_x;
  assign box_y = r_box_y;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Two-stage RGB test-pattern generator driven by col/row counts;
//               syncs are delayed to stay aligned with the video.
// Revision    : 1.0  initial release
// ============================================================================
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int COLOR_BITS  = DEF_COLOR_BITS,
  parameter int BOX_SIZE    = DEF_BOX_SIZE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ihsync,
  input  logic                  ivsync,
  input  logic [9:0]            col,
  input  logic [9:0]            row,
  input  logic [2:0]            pattern_sel,
  output logic                  ohsync,
  output logic                  ovsync,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] grn,
  output logic [COLOR_BITS-1:0] blu
);

  localparam int              c_bar_w = ACTIVE_COLS / 8;
  localparam [COLOR_BITS-1:0] c_max   = {COLOR_BITS{1'b1}};

  logic       w_frame_start, w_vblank_strobe, w_active, w_box_hit;
  logic [2:0] w_bar;
  logic [9:0] w_box_x, w_box_y;

  logic                  r_s1_active, r_s1_hsync, r_s1_vsync, r_s1_box, r_s1_check;
  logic [2:0]            r_s1_bar;
  logic [COLOR_BITS-1:0] r_s1_ramp;
  logic [2:0]            r_active_pattern;
  logic [COLOR_BITS-1:0] w_red, w_grn, w_blu;
  logic [2:0]            w_code;

  assign w_frame_start   = (col == 10'd0) && (row == 10'd0);
  assign w_vblank_strobe = (col == 10'd0) && (row == 10'(ACTIVE_ROWS));
  // Out-of-range counts are folded into blanking
  assign w_active = (int'(col) < TOTAL_COLS) && (int'(row) < TOTAL_ROWS) &&
                    (int'(col) < ACTIVE_COLS) && (int'(row) < ACTIVE_ROWS);
  assign w_box_hit = (col >= w_box_x) && ({1'b0, col} < ({1'b0, w_box_x} + 11'(BOX_SIZE))) &&
                     (row >= w_box_y) && ({1'b0, row} < ({1'b0, w_box_y} + 11'(BOX_SIZE)));

  // Bar index from threshold comparisons rather than a divider
  always_comb begin
    w_bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(col) >= i * c_bar_w) w_bar = 3'(i);
    end
  end

  vga_box_mover #(
    .ACTIVE_COLS (ACTIVE_COLS),
    .ACTIVE_ROWS (ACTIVE_ROWS),
    .BOX_SIZE    (BOX_SIZE)
  ) u_box_mover (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe  (w_vblank_strobe),
    .box_x   (w_box_x),
    .box_y   (w_box_y)
  );

  // Stage 1: register per-pixel attributes, syncs, and latch pattern at frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_active      <= 1'b0;
      r_s1_hsync       <= 1'b0;
      r_s1_vsync       <= 1'b0;
      r_s1_box         <= 1'b0;
      r_s1_check       <= 1'b0;
      r_s1_bar         <= 3'd0;
      r_s1_ramp        <= '0;
      r_active_pattern <= PAT_BLACK;
    end else begin
      r_s1_active <= w_active;
      r_s1_hsync  <= ihsync;
      r_s1_vsync  <= ivsync;
      r_s1_box    <= w_box_hit;
      r_s1_check  <= col[5] ^ row[5];
      r_s1_bar    <= w_bar;
      r_s1_ramp   <= col[9 -: COLOR_BITS];
      if (w_frame_start) r_active_pattern <= pattern_sel;
    end
  end

  // Colour mux; blanking forces black whatever the pattern
  always_comb begin
    w_red  = '0;
    w_grn  = '0;
    w_blu  = '0;
    w_code = bar_colour(r_s1_bar);
    if (r_s1_active) begin
      case (r_active_pattern)
        PAT_BLACK: ;
        PAT_WHITE: begin
          w_red = c_max; w_grn = c_max; w_blu = c_max;
        end
        PAT_BARS: begin
          w_red = {COLOR_BITS{w_code[2]}};
          w_grn = {COLOR_BITS{w_code[1]}};
          w_blu = {COLOR_BITS{w_code[0]}};
        end
        PAT_CHECKER: begin
          if (r_s1_check) begin
            w_red = c_max; w_grn = c_max; w_blu = c_max;
          end
        end
        PAT_BOX: begin
          w_blu = c_max;
          if (r_s1_box) begin
            w_red = c_max; w_grn = c_max;
          end
        end
        PAT_RAMP: begin
          w_red = r_s1_ramp; w_grn = r_s1_ramp; w_blu = r_s1_ramp;
        end
        default: ;
      endcase
    end
  end

  // Stage 2: register colour and syncs together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      red    <= '0;
      grn    <= '0;
      blu    <= '0;
      ohsync <= 1'b0;
      ovsync <= 1'b0;
    end else begin
      red    <= w_red;
      grn    <= w_grn;
      blu    <= w_blu;
      ohsync <= r_s1_hsync;
      ovsync <= r_s1_vsync;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Directed self-checking bench for vga_pattern_gen.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  localparam logic [8:0] c_w = 9'o777;   // {red,grn,blu}, one octal digit each
  localparam logic [8:0] c_b = 9'o007;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    logic [9:0] c;
    logic [9:0] r;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       ihsync = 1'b0, ivsync = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic [2:0] pattern_sel = '0;
  logic       ohsync, ovsync;
  logic [2:0] red, grn, blu;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t p0 = '0, p1 = '0;
  logic [8:0] bars [8] = '{9'o777, 9'o770, 9'o077, 9'o070, 9'o707, 9'o700, 9'o007, 9'o000};

  vga_pattern_gen u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ihsync      (ihsync),
    .ivsync      (ivsync),
    .col         (col),
    .row         (row),
    .pattern_sel (pattern_sel),
    .ohsync      (ohsync),
    .ovsync      (ovsync),
    .red         (red),
    .grn         (grn),
    .blu         (blu)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one pixel; the outputs now visible belong to the vector two calls back
  task automatic cyc(input int c, input int r, input logic hs, input logic vs, input logic [8:0] rgb);
    check($sformatf("sync(%0d,%0d)", p1.c, p1.r), {14'd0, ohsync, ovsync}, {14'd0, p1.hs, p1.vs});
    check($sformatf("rgb(%0d,%0d)", p1.c, p1.r), {7'd0, red, grn, blu}, {7'd0, p1.rgb});
    p1 = p0;
    p0 = '{hs: hs, vs: vs, rgb: rgb, c: 10'(c), r: 10'(r)};
    col = 10'(c); row = 10'(r); ihsync = hs; ivsync = vs;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    col = '0; row = '0; ihsync = 1'b0; ivsync = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_rgb",  {7'd0, red, grn, blu}, 16'd0);
    check("reset_sync", {14'd0, ohsync, ovsync}, 16'd0);
    reset_n = 1'b1;
    p0 = '0; p1 = '0;
  endtask

  // One compressed frame: vblank strobe plus two cycles for the X and Y steps
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      cyc(0, 480, 1'b0, 1'b1, 9'o000);
      cyc(1, 480, 1'b0, 1'b1, 9'o000);
      cyc(2, 480, 1'b1, 1'b1, 9'o000);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    @(negedge clock);
    do_reset();

    // White, taking effect only from the frame start
    pattern_sel = 3'd1;
    cyc(5, 5, 0, 0, 9'o000);
    cyc(0, 0, 1, 1, c_w);
    cyc(1, 0, 0, 1, c_w);
    cyc(639, 479, 1, 0, c_w);
    cyc(640, 479, 1, 1, 9'o000);
    cyc(10, 10, 1, 1, c_w);
    cyc(11, 10, 1, 1, c_w);
    cyc(12, 10, 1, 1, c_w);

    // Asynchronous reset mid-line clears outputs at once
    #2 reset_n = 1'b0;
    #1 check("midrst_rgb",  {7'd0, red, grn, blu}, 16'd0);
    check("midrst_sync", {14'd0, ohsync, ovsync}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    p0 = '0; p1 = '0;
    cyc(20, 20, 1, 0, 9'o000);
    cyc(21, 20, 0, 1, 9'o000);
    cyc(0, 0, 0, 0, c_w);
    cyc(5, 100, 1, 0, c_w);

    // Switch to checkerboard mid-frame: white holds until next frame start
    pattern_sel = 3'd3;
    cyc(50, 100, 0, 0, c_w);
    cyc(639, 479, 0, 0, c_w);
    cyc(0, 0, 1, 0, 9'o000);
    cyc(32, 0, 0, 1, c_w);
    cyc(32, 32, 0, 0, 9'o000);
    cyc(0, 32, 1, 1, c_w);
    cyc(63, 63, 0, 0, 9'o000);
    cyc(64, 0, 0, 0, 9'o000);
    cyc(96, 0, 1, 0, c_w);
    cyc(700, 32, 0, 0, 9'o000);

    // Colour bars across a full line including blanking
    pattern_sel = 3'd2;
    cyc(0, 0, 0, 0, c_w);
    for (int c = 0; c < 800; c++) cyc(c, 10, rb(), rb(), (c < 640) ? bars[c / 80] : 9'o000);

    // Horizontal ramp
    pattern_sel = 3'd5;
    cyc(0, 0, 0, 0, 9'o000);
    cyc(127, 1, 1, 0, 9'o000);
    cyc(128, 1, 0, 1, 9'o111);
    cyc(300, 1, 1, 1, 9'o222);
    cyc(511, 5, 0, 0, 9'o333);
    cyc(512, 5, 1, 0, 9'o444);
    cyc(639, 479, 0, 1, 9'o444);
    cyc(640, 1, 1, 1, 9'o000);

    // Reserved codes are black, syncs still pass through
    pattern_sel = 3'd6;
    cyc(0, 0, rb(), rb(), 9'o000);
    cyc(100, 100, rb(), rb(), 9'o000);
    pattern_sel = 3'd7;
    cyc(0, 0, rb(), rb(), 9'o000);
    cyc(200, 300, rb(), rb(), 9'o000);

    // Out-of-range counts blank without disturbing later pixels
    pattern_sel = 3'd1;
    cyc(0, 0, 0, 0, c_w);
    cyc(900, 10, 1, 0, 9'o000);
    cyc(1023, 1023, 0, 1, 9'o000);
    cyc(10, 600, 1, 1, 9'o000);
    cyc(20, 20, 0, 0, c_w);

    // Bouncing box
    do_reset();
    pattern_sel = 3'd4;
    cyc(0, 0, 0, 0, c_w);
    cyc(31, 31, 0, 0, c_w);
    cyc(32, 0, 0, 0, c_b);
    cyc(0, 32, 0, 0, c_b);
    frames(608);                       // x = 608, y = 896-608 = 288
    cyc(608, 288, 0, 0, c_w);
    cyc(607, 288, 0, 0, c_b);
    cyc(639, 319, 0, 0, c_w);
    cyc(608, 320, 0, 0, c_b);
    cyc(608, 287, 0, 0, c_b);
    frames(1);                         // x = 607, y = 287
    cyc(607, 287, 0, 0, c_w);
    cyc(639, 287, 0, 0, c_b);
    frames(91);                        // x = 516, y = 196
    cyc(516, 196, 0, 0, c_w);
    cyc(515, 196, 0, 0, c_b);
    cyc(547, 227, 0, 0, c_w);
    cyc(548, 227, 0, 0, c_b);
    cyc(799, 524, 0, 0, 9'o000);
    cyc(799, 524, 0, 0, 9'o000);
    cyc(799, 524, 0, 0, 9'o000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
